// File: rtl/strela_pkg.sv
// Shared types for the STRELA register-bus driver: command ops, queued command,
// driver FSM states, register-bus request/response and the POLL compare helper.
package strela_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } strela_reg_op_e;

  typedef struct packed {
    strela_reg_op_e op;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic [31:0]    mask;
  } strela_reg_cmd_t;

  typedef enum logic [1:0] {
    DRV_IDLE  = 2'd0,
    DRV_ISSUE = 2'd1,
    DRV_GAP   = 2'd2,
    DRV_DONE  = 2'd3
  } strela_drv_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  // Only bits set in mask take part in the compare; mask 0 always matches.
  function automatic logic poll_match(input logic [31:0] rdata,
                                      input logic [31:0] expected,
                                      input logic [31:0] mask);
    return ((rdata ^ expected) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/strela_reg_driver_if.sv
// Register-bus link between the STRELA driver (master) and the MMIO register file (slave).
// A transfer completes on a cycle with req.valid && rsp.ready; the master holds req stable until then.
interface strela_reg_driver_if;
  import strela_pkg::*;

  reg_req_t req;
  reg_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/strela_cmd_fifo.sv
// Command queue of strela_reg_cmd_t entries; no pass-through, flush empties the queue
// and drops any push in the same cycle.
module strela_cmd_fifo
  import strela_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  strela_reg_cmd_t din_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output strela_reg_cmd_t dout_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  strela_reg_cmd_t mem_q [DEPTH];
  strela_reg_cmd_t mem_d [DEPTH];
  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      rptr_d = wptr_q;
    end else begin
      if (push_i && !full_o) begin
        mem_d[wptr_q[AW-1:0]] = din_i;
        wptr_d = wptr_q + PTR_ONE;
      end
      if (pop_i && !empty_o) begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/strela_reg_driver.sv
// STRELA register-bus initiator: queues WRITE/READ/POLL commands and issues them one at a time.
// Define STRELA_REG_DRIVER_ERR_ABORT_EN to flush the queue when a command completes with a bus error.
module strela_reg_driver
  import strela_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [31:0]         cmd_addr_i,
  input  logic [31:0]         cmd_wdata_i,
  input  logic [31:0]         cmd_mask_i,
  output logic                rsp_valid_o,
  output logic [31:0]         rsp_rdata_o,
  output logic                rsp_error_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  strela_reg_driver_if.master reg_if,
  output strela_drv_state_e   dbg_state_o
);

  localparam int PCW = (POLL_TIMEOUT > 0) ? $clog2(POLL_TIMEOUT + 1) : 1;
  localparam logic [PCW-1:0] POLL_ONE = 1;
  localparam logic [PCW-1:0] POLL_LIM = PCW'(POLL_TIMEOUT);

  strela_drv_state_e state_q, state_d;
  strela_reg_cmd_t   cmd_q, cmd_d, cmd_in, fifo_dout;
  logic [PCW-1:0]    poll_cnt_q, poll_cnt_d, poll_nxt;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic              poll_hit, poll_at_limit;

  assign cmd_in = '{op: strela_reg_op_e'(cmd_op_i), addr: cmd_addr_i,
                    wdata: cmd_wdata_i, mask: cmd_mask_i};

  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && !fifo_full;
  assign fifo_pop    = (state_q == DRV_IDLE) && !fifo_empty;

`ifdef STRELA_REG_DRIVER_ERR_ABORT_EN
  assign fifo_flush = (state_q == DRV_DONE) && rsp_error_q;
`else
  assign fifo_flush = 1'b0;
`endif

  strela_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .din_i   (cmd_in),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign reg_if.req.valid = (state_q == DRV_ISSUE);
  assign reg_if.req.addr  = cmd_q.addr;
  assign reg_if.req.write = (cmd_q.op == OP_WRITE);
  assign reg_if.req.wdata = cmd_q.wdata;
  assign reg_if.req.wstrb = (cmd_q.op == OP_WRITE) ? 4'hF : 4'h0;

  assign poll_hit      = poll_match(reg_if.rsp.rdata, cmd_q.wdata, cmd_q.mask);
  assign poll_nxt      = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + POLL_ONE;
  assign poll_at_limit = (POLL_TIMEOUT != 0) && (poll_nxt == POLL_LIM);

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    poll_cnt_d    = poll_cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      DRV_IDLE: begin
        if (!fifo_empty) begin
          cmd_d      = fifo_dout;
          poll_cnt_d = '0;
          state_d    = DRV_ISSUE;
        end
      end
      DRV_ISSUE: begin
        if (reg_if.rsp.ready) begin
          // Response registers only change on the completing access so rsp_* holds between commands.
          if (cmd_q.op != OP_POLL || reg_if.rsp.error || poll_hit || poll_at_limit) begin
            rsp_rdata_d   = (cmd_q.op == OP_WRITE) ? 32'h0 : reg_if.rsp.rdata;
            rsp_error_d   = reg_if.rsp.error;
            rsp_timeout_d = (cmd_q.op == OP_POLL) && !reg_if.rsp.error && !poll_hit;
            state_d       = DRV_DONE;
          end else begin
            if (POLL_TIMEOUT != 0) poll_cnt_d = poll_nxt;
            state_d = DRV_GAP;
          end
        end
      end
      DRV_GAP:  state_d = DRV_ISSUE;
      DRV_DONE: state_d = DRV_IDLE;
      default:  state_d = DRV_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= DRV_IDLE;
      cmd_q         <= '0;
      poll_cnt_q    <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      poll_cnt_q    <= poll_cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_valid_o   = (state_q == DRV_DONE);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = !fifo_empty || (state_q != DRV_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_strela_reg_driver.sv
// Bench for strela_reg_driver: directed scenarios plus random command batches, a register-file
// responder, and a command-level reference model feeding expected-response/access queues.
module tb_strela_reg_driver;
  import strela_pkg::*;

  localparam int PT = 4;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  logic              cmd_valid_i, cmd_ready_o;
  logic [1:0]        cmd_op_i;
  logic [31:0]       cmd_addr_i, cmd_wdata_i, cmd_mask_i;
  logic              rsp_valid_o, rsp_error_o, rsp_timeout_o, busy_o;
  logic [31:0]       rsp_rdata_o;
  strela_drv_state_e dbg_state_o;

  strela_reg_driver_if reg_if ();

  strela_reg_driver #(.FIFO_DEPTH(4), .POLL_TIMEOUT(PT)) dut (
    .clk_i (clk_i), .rst_i (rst_i),
    .cmd_valid_i (cmd_valid_i), .cmd_ready_o (cmd_ready_o), .cmd_op_i (cmd_op_i),
    .cmd_addr_i (cmd_addr_i), .cmd_wdata_i (cmd_wdata_i), .cmd_mask_i (cmd_mask_i),
    .rsp_valid_o (rsp_valid_o), .rsp_rdata_o (rsp_rdata_o), .rsp_error_o (rsp_error_o),
    .rsp_timeout_o (rsp_timeout_o), .busy_o (busy_o),
    .reg_if (reg_if.master), .dbg_state_o (dbg_state_o)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];      // {rdata, error, timeout}
  logic [69:0] exp_acc_q[$];  // {gap_chk, addr, write, wdata, wstrb}
  logic [31:0] rmem [64];
  logic [31:0] mmem [64];
  logic [31:0] rscript[$];
  logic [31:0] mscript[$];
  logic [31:0] err_addr;
  int          rsp_delay;
  int          wait_cnt;
  int          n_acc;
  int          last_acc_cyc;
  reg_req_t    held;

  logic [1:0]  b_op[$];
  logic [31:0] b_addr[$];
  logic [31:0] b_wdata[$];
  logic [31:0] b_mask[$];

  // ---------------- register-file responder ----------------
  always @(negedge clk_i) begin
    logic [31:0] d;
    logic        e;
    logic [69:0] a, ea;
    if (rst_i) begin
      reg_if.rsp = '0;
      wait_cnt   = 0;
    end else if (!reg_if.req.valid) begin
      if (wait_cnt != 0) check("req_held", 70'(reg_if.req.valid), 70'd1);
      reg_if.rsp = '0;
      wait_cnt   = 0;
    end else begin
      if (wait_cnt == 0) held = reg_if.req;
      else check("req_stable", reg_if.req, held);
      if (wait_cnt < rsp_delay) begin
        reg_if.rsp.ready = 1'b0;
        wait_cnt++;
      end else begin
        e = (reg_if.req.addr == err_addr);
        d = 32'h0;
        if (!reg_if.req.write) d = (rscript.size() != 0) ? rscript.pop_front() : rmem[reg_if.req.addr[7:2]];
        else if (!e) rmem[reg_if.req.addr[7:2]] = reg_if.req.wdata;
        a = {1'b0, reg_if.req.addr, reg_if.req.write,
             reg_if.req.write ? reg_if.req.wdata : 32'h0, reg_if.req.wstrb};
        if (exp_acc_q.size() == 0) begin
          check("access_extra", 70'(exp_acc_q.size()), 70'd1);
        end else begin
          ea = exp_acc_q.pop_front();
          if (ea[69]) check("poll_gap", 70'(cyc - last_acc_cyc), 70'(rsp_delay + 2));
          check("access", a, {1'b0, ea[68:0]});
        end
        last_acc_cyc = cyc;
        n_acc++;
        reg_if.rsp = '{ready: 1'b1, rdata: d, error: e};
        wait_cnt   = 0;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk_i) begin
    logic [33:0] e;
    if (!rst_i && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("rsp_extra", 70'(exp_q.size()), 70'd1);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", 70'(rsp_rdata_o), 70'(e[33:2]));
        check("rsp_error", 70'(rsp_error_o), 70'(e[1]));
        check("rsp_timeout", 70'(rsp_timeout_o), 70'(e[0]));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (mscript.size() != 0) return mscript.pop_front();
    return mmem[a[7:2]];
  endfunction

  task automatic model_batch();
    logic [31:0] d;
    logic        e;
    bit          stop, done;
    int          n;
    stop = 0;
    for (int i = 0; i < b_op.size(); i++) begin
      if (!stop) begin
        e = (b_addr[i] == err_addr);
        if (b_op[i] == 2'd0) begin
          exp_acc_q.push_back({1'b0, b_addr[i], 1'b1, b_wdata[i], 4'hF});
          if (!e) mmem[b_addr[i][7:2]] = b_wdata[i];
          exp_q.push_back({32'h0, e, 1'b0});
        end else if (b_op[i] == 2'd2) begin
          n = 0;
          done = 0;
          while (!done) begin
            d = model_read(b_addr[i]);
            exp_acc_q.push_back({(n != 0), b_addr[i], 1'b0, 32'h0, 4'h0});
            n++;
            if (e || ((d ^ b_wdata[i]) & b_mask[i]) == 32'h0) begin
              exp_q.push_back({d, e, 1'b0});
              done = 1;
            end else if (n == PT) begin
              exp_q.push_back({d, 1'b0, 1'b1});
              done = 1;
            end
          end
        end else begin
          d = model_read(b_addr[i]);
          exp_acc_q.push_back({1'b0, b_addr[i], 1'b0, 32'h0, 4'h0});
          exp_q.push_back({d, e, 1'b0});
        end
`ifdef STRELA_REG_DRIVER_ERR_ABORT_EN
        if (e) stop = 1;
`endif
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_cmd(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mask);
    b_op.push_back(op);
    b_addr.push_back(addr);
    b_wdata.push_back(wdata);
    b_mask.push_back(mask);
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] mask);
    int budget;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_mask_i  = mask;
    budget = 300;
    while (!cmd_ready_o && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) check("push_timeout", 70'(cmd_ready_o), 70'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 3000;
    while ((busy_o || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk_i);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 70'(busy_o), 70'd0);
    check("exp_rsp_left", 70'(exp_q.size()), 70'd0);
    check("exp_acc_left", 70'(exp_acc_q.size()), 70'd0);
    @(negedge clk_i);
  endtask

  task automatic run_batch();
    model_batch();
    for (int i = 0; i < b_op.size(); i++) push_cmd(b_op[i], b_addr[i], b_wdata[i], b_mask[i]);
    wait_idle();
    b_op.delete();
    b_addr.delete();
    b_wdata.delete();
    b_mask.delete();
  endtask

  task automatic set_script(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    rscript = '{v0, v1, v2};
    mscript = '{v0, v1, v2};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    cmd_valid_i  = 1'b0;
    cmd_op_i     = 2'd0;
    cmd_addr_i   = '0;
    cmd_wdata_i  = '0;
    cmd_mask_i   = '0;
    rsp_delay    = 0;
    err_addr     = 32'hFFFF_FFF0;
    n_acc        = 0;
    last_acc_cyc = 0;
    for (int i = 0; i < 64; i++) begin
      rmem[i] = $urandom;
      mmem[i] = rmem[i];
    end
    repeat (3) @(negedge clk_i);
    check("rst_req_valid", 70'(reg_if.req.valid), 70'd0);
    check("rst_busy", 70'(busy_o), 70'd0);
    check("rst_rsp_valid", 70'(rsp_valid_o), 70'd0);
    check("rst_rsp_rdata", 70'(rsp_rdata_o), 70'd0);
    check("rst_cmd_ready", 70'(cmd_ready_o), 70'd1);
    rst_i = 1'b0;
    @(negedge clk_i);

    // write then read back
    add_cmd(2'd0, 32'h0C, 32'h1234_0000, 32'h0);
    add_cmd(2'd1, 32'h0C, 32'h0, 32'h0);
    run_batch();
    check("wr_rd_rdata", 70'(rsp_rdata_o), 70'h1234_0000);

    // poll matching on the third read, then a mask-0 poll matching at once
    set_script(32'h0, 32'h0, 32'h1);
    add_cmd(2'd2, 32'h04, 32'h1, 32'h1);
    add_cmd(2'd2, 32'h10, 32'hFFFF, 32'h0);
    run_batch();

    // poll that never matches
    add_cmd(2'd0, 32'h08, 32'h0, 32'h0);
    add_cmd(2'd2, 32'h08, 32'h1, 32'hFFFF_FFFF);
    run_batch();
    check("poll_tmo_flag", 70'(rsp_timeout_o), 70'd1);
    check("poll_tmo_rdata", 70'(rsp_rdata_o), 70'd0);

    // slow responder: request must hold for 6 cycles
    rsp_delay = 5;
    add_cmd(2'd0, 32'h14, 32'hA5A5_0001, 32'h0);
    run_batch();

    // queue fills while the first write stalls
    rsp_delay = 12;
    for (int i = 0; i < 6; i++) add_cmd(2'd0, 32'h20 + 32'(4 * i), $urandom, 32'h0);
    model_batch();
    n0 = n_acc;
    for (int i = 0; i < 5; i++) push_cmd(b_op[i], b_addr[i], b_wdata[i], b_mask[i]);
    check("fifo_full_ready", 70'(cmd_ready_o), 70'd0);
    push_cmd(b_op[5], b_addr[5], b_wdata[5], b_mask[5]);
    check("push_after_pop", 70'(n_acc > n0), 70'd1);
    wait_idle();
    b_op.delete(); b_addr.delete(); b_wdata.delete(); b_mask.delete();
    rsp_delay = 0;

    // erroring read with two writes queued behind it
    err_addr = 32'h30;
    add_cmd(2'd1, 32'h30, 32'h0, 32'h0);
    add_cmd(2'd0, 32'h34, 32'h5555_AAAA, 32'h0);
    add_cmd(2'd0, 32'h38, 32'h0F0F_F0F0, 32'h0);
    run_batch();
    err_addr = 32'hFFFF_FFF0;

    // random batches
    for (int b = 0; b < 4; b++) begin
      rsp_delay = $urandom_range(0, 2);
      for (int i = 0; i < 6; i++)
        add_cmd(2'($urandom_range(0, 3)), {26'h0, 4'($urandom_range(0, 15)), 2'b00},
                $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'h0);
      run_batch();
    end
    rsp_delay = 0;

    // reset while a stalled access is in flight
    rsp_delay = 20;
    push_cmd(2'd1, 32'h00, 32'h0, 32'h0);
    push_cmd(2'd1, 32'h04, 32'h0, 32'h0);
    @(negedge clk_i);
    check("pre_rst_valid", 70'(reg_if.req.valid), 70'd1);
    #2 rst_i = 1'b1;
    #1;
    check("rst_mid_valid", 70'(reg_if.req.valid), 70'd0);
    check("rst_mid_busy", 70'(busy_o), 70'd0);
    repeat (2) @(negedge clk_i);
    rsp_delay = 0;
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("post_rst_busy", 70'(busy_o), 70'd0);
    check("post_rst_valid", 70'(reg_if.req.valid), 70'd0);

    // recovery after reset
    add_cmd(2'd1, 32'h0C, 32'h0, 32'h0);
    run_batch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
